// File: rtl/systolic_array.sv
// 2x2 output-stationary systolic multiply-accumulate tile. A operands shift east,
// B operands shift south, and each PE accumulates the product of the operands entering it.
module systolic_array #(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [DATA_W-1:0] N_RX0,
    input  logic [DATA_W-1:0] N_RX1,
    input  logic [DATA_W-1:0] N_CX0,
    input  logic [DATA_W-1:0] N_CX1,
    output logic [DATA_W-1:0] N_RY0,
    output logic [DATA_W-1:0] N_RY1,
    output logic [DATA_W-1:0] N_CY0,
    output logic [DATA_W-1:0] N_CY1,
    output logic [DATA_W-1:0] ACC00,
    output logic [DATA_W-1:0] ACC01,
    output logic [DATA_W-1:0] ACC10,
    output logic [DATA_W-1:0] ACC11
);

    logic [DATA_W-1:0] westIn  [2];
    logic [DATA_W-1:0] northIn [2];
    logic [DATA_W-1:0] aFwd    [2][2];
    logic [DATA_W-1:0] bFwd    [2][2];
    logic [DATA_W-1:0] accOut  [2][2];

    assign westIn[0]  = N_RX0;
    assign westIn[1]  = N_RX1;
    assign northIn[0] = N_CX0;
    assign northIn[1] = N_CX1;

    genvar gi, gj;
    generate
        for (gi = 0; gi < 2; gi++) begin : gRow
            for (gj = 0; gj < 2; gj++) begin : gCol
                logic [DATA_W-1:0] aIn;
                logic [DATA_W-1:0] bIn;
                logic [DATA_W-1:0] aReg;
                logic [DATA_W-1:0] bReg;
                logic [DATA_W-1:0] accReg;

                if (gj == 0) begin : gWestEdge
                    assign aIn = westIn[gi];
                end else begin : gFromWest
                    assign aIn = aFwd[gi][gj-1];
                end

                if (gi == 0) begin : gNorthEdge
                    assign bIn = northIn[gj];
                end else begin : gFromNorth
                    assign bIn = bFwd[gi-1][gj];
                end

                // MAC uses the incoming operands, so the product lands in the same edge they are captured.
                always_ff @(posedge CLK) begin
                    if (RST) begin
                        aReg   <= '0;
                        bReg   <= '0;
                        accReg <= '0;
                    end else if (EN) begin
                        aReg   <= aIn;
                        bReg   <= bIn;
                        accReg <= accReg + aIn * bIn;
                    end
                end

                assign aFwd[gi][gj]   = aReg;
                assign bFwd[gi][gj]   = bReg;
                assign accOut[gi][gj] = accReg;
            end
        end
    endgenerate

    assign N_RY0 = aFwd[0][1];
    assign N_RY1 = aFwd[1][1];
    assign N_CY0 = bFwd[1][0];
    assign N_CY1 = bFwd[1][1];

    assign ACC00 = accOut[0][0];
    assign ACC01 = accOut[0][1];
    assign ACC10 = accOut[1][0];
    assign ACC11 = accOut[1][1];

endmodule

// File: tb/tb_systolic_array.sv
// Bench for systolic_array: directed jobs from the test plan plus a random run,
// all checked against a matrix/delay-line reference model.
module tb_systolic_array;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic [31:0] N_RX0, N_RX1, N_CX0, N_CX1;
    logic [31:0] N_RY0, N_RY1, N_CY0, N_CY1;
    logic [31:0] ACC00, ACC01, ACC10, ACC11;

    int compared   = 0;
    int mismatched = 0;

    // Reference: accumulated sums and per-input history of enabled samples (index 0 = newest).
    logic [31:0] expAcc [2][2];
    logic [31:0] rxHist [2][2];
    logic [31:0] cxHist [2][2];

    logic [31:0] jobRx0 [5] = '{32'd1, 32'd2, 32'd0, 32'd0, 32'd0};
    logic [31:0] jobRx1 [5] = '{32'd0, 32'd3, 32'd4, 32'd0, 32'd0};
    logic [31:0] jobCx0 [5] = '{32'd5, 32'd7, 32'd0, 32'd0, 32'd0};
    logic [31:0] jobCx1 [5] = '{32'd0, 32'd6, 32'd8, 32'd0, 32'd0};

    systolic_array #(.DATA_W(32)) dut (
        .CLK(CLK), .RST(RST), .EN(EN),
        .N_RX0(N_RX0), .N_RX1(N_RX1), .N_CX0(N_CX0), .N_CX1(N_CX1),
        .N_RY0(N_RY0), .N_RY1(N_RY1), .N_CY0(N_CY0), .N_CY1(N_CY1),
        .ACC00(ACC00), .ACC01(ACC01), .ACC10(ACC10), .ACC11(ACC11)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                expAcc[i][j] = '0;
                rxHist[i][j] = '0;
                cxHist[i][j] = '0;
            end
    endtask

    // PE(i,j) sees row i's input delayed j edges and column j's input delayed i edges.
    task automatic modelEdge(input logic rst, input logic en, input logic [31:0] r0, r1, c0, c1);
        if (rst) begin
            modelReset();
        end else if (en) begin
            for (int k = 0; k < 2; k++) begin
                rxHist[k][1] = rxHist[k][0];
                cxHist[k][1] = cxHist[k][0];
            end
            rxHist[0][0] = r0;
            rxHist[1][0] = r1;
            cxHist[0][0] = c0;
            cxHist[1][0] = c1;
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++)
                    expAcc[i][j] = expAcc[i][j] + rxHist[i][j] * cxHist[j][i];
        end
    endtask

    task automatic checkAll(input string tag);
        check({tag, ".ACC00"}, ACC00, expAcc[0][0]);
        check({tag, ".ACC01"}, ACC01, expAcc[0][1]);
        check({tag, ".ACC10"}, ACC10, expAcc[1][0]);
        check({tag, ".ACC11"}, ACC11, expAcc[1][1]);
        check({tag, ".N_RY0"}, N_RY0, rxHist[0][1]);
        check({tag, ".N_RY1"}, N_RY1, rxHist[1][1]);
        check({tag, ".N_CY0"}, N_CY0, cxHist[0][1]);
        check({tag, ".N_CY1"}, N_CY1, cxHist[1][1]);
    endtask

    task automatic step(input string tag, input logic rst, input logic en,
                        input logic [31:0] r0, r1, c0, c1);
        @(negedge CLK);
        RST = rst; EN = en;
        N_RX0 = r0; N_RX1 = r1; N_CX0 = c0; N_CX1 = c1;
        @(posedge CLK);
        modelEdge(rst, en, r0, r1, c0, c1);
        #1;
        $display("edge %s rst=%0b en=%0b in=%h/%h/%h/%h acc=%0d/%0d/%0d/%0d",
                 tag, rst, en, r0, r1, c0, c1, ACC00, ACC01, ACC10, ACC11);
        checkAll(tag);
    endtask

    task automatic checkResult(input string tag, input logic [31:0] e00, e01, e10, e11);
        check({tag, ".C00"}, ACC00, e00);
        check({tag, ".C01"}, ACC01, e01);
        check({tag, ".C10"}, ACC10, e10);
        check({tag, ".C11"}, ACC11, e11);
    endtask

    // Basic 2x2 job; stallAfter>0 inserts two EN=0 edges after that enabled edge.
    task automatic runJob(input string tag, input int stallAfter);
        for (int e = 0; e < 5; e++) begin
            step(tag, 1'b0, 1'b1, jobRx0[e], jobRx1[e], jobCx0[e], jobCx1[e]);
            if (e == 1) check({tag, ".RY0@2"}, N_RY0, 32'd1);
            if (e == 2) check({tag, ".RY0@3"}, N_RY0, 32'd2);
            if (e == 2) check({tag, ".CY1@3"}, N_CY1, 32'd6);
            if (e == 3) check({tag, ".CY1@4"}, N_CY1, 32'd8);
            if (e + 1 == stallAfter)
                for (int s = 0; s < 2; s++)
                    step({tag, ".stall"}, 1'b0, 1'b0, jobRx0[e+1], jobRx1[e+1], jobCx0[e+1], jobCx1[e+1]);
        end
    endtask

    initial begin
        modelReset();
        RST = 1'b1; EN = 1'b0;
        N_RX0 = '0; N_RX1 = '0; N_CX0 = '0; N_CX1 = '0;

        // Reset priority: RST with EN=0 and nonzero inputs clears everything.
        step("rstprio", 1'b1, 1'b0, 32'h1234_5678, 32'h9, 32'hDEAD_BEEF, 32'h7);

        runJob("basic", 0);
        checkResult("basic", 32'd19, 32'd22, 32'd43, 32'd50);

        runJob("accum", 0);
        checkResult("accum", 32'd38, 32'd44, 32'd86, 32'd100);

        step("rst1", 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        runJob("hold", 2);
        checkResult("hold", 32'd19, 32'd22, 32'd43, 32'd50);

        // Reset mid-run discards partial sums and in-flight operands.
        step("rst2", 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        for (int e = 0; e < 2; e++)
            step("mid", 1'b0, 1'b1, jobRx0[e], jobRx1[e], jobCx0[e], jobCx1[e]);
        step("midrst", 1'b1, 1'b1, jobRx0[2], jobRx1[2], jobCx0[2], jobCx1[2]);
        checkResult("midrst", 32'd0, 32'd0, 32'd0, 32'd0);
        check("midrst.RY0", N_RY0, 32'd0);
        check("midrst.CY0", N_CY0, 32'd0);
        runJob("rerun", 0);
        checkResult("rerun", 32'd19, 32'd22, 32'd43, 32'd50);

        // Wrap-around: product truncates to the low 32 bits.
        step("rst3", 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        step("wrap", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd2, 32'd0);
        for (int e = 0; e < 3; e++)
            step("wrapz", 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);
        checkResult("wrap", 32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0);

        // Random stream with random enable and occasional reset.
        step("rst4", 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        for (int n = 0; n < 60; n++)
            step("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 $urandom, $urandom, $urandom, $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/systolic_array.md
Name: systolic_array

Overview:
- 2x2 output-stationary systolic matrix-multiply tile.
- Row operands (A) enter on the west edge and shift east. Column operands (B) enter on the north edge and shift south.
- Each of the 4 processing elements (PEs) accumulates the products of the operands passing through it.
- East and south edge outputs forward operands so tiles can be cascaded into larger arrays. Per-PE accumulators are exposed for result readout.

Parameters:
- DATA_W, 32, width of every operand, forwarded operand and accumulator.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  global advance enable; when low, all state holds.
- N_RX0  in  DATA_W  west input, row 0 (A row 0, skewed).
- N_RX1  in  DATA_W  west input, row 1 (A row 1, skewed by one cycle).
- N_CX0  in  DATA_W  north input, column 0 (B column 0, skewed).
- N_CX1  in  DATA_W  north input, column 1 (B column 1, skewed by one cycle).
- N_RY0  out  DATA_W  east output, row 0 (PE01 forwarded A register).
- N_RY1  out  DATA_W  east output, row 1 (PE11 forwarded A register).
- N_CY0  out  DATA_W  south output, column 0 (PE10 forwarded B register).
- N_CY1  out  DATA_W  south output, column 1 (PE11 forwarded B register).
- ACC00, ACC01, ACC10, ACC11  out  DATA_W each  accumulator of PE(row,col).

Behaviour:
- PE(i,j) holds three registers: a_reg, b_reg, acc.
- PE operand sources:
  - a_in: PE00=N_RX0, PE10=N_RX1, PE01=PE00.a_reg, PE11=PE10.a_reg.
  - b_in: PE00=N_CX0, PE01=N_CX1, PE10=PE00.b_reg, PE11=PE01.b_reg.
- Rising edge with RST=1: every a_reg, b_reg and acc goes to 0, regardless of EN. All outputs read 0 from the next cycle.
- Rising edge with RST=0 and EN=1, per PE:
  - a_reg <= a_in
  - b_reg <= b_in
  - acc <= acc + a_in*b_in
- Rising edge with RST=0 and EN=0: all registers hold.
- Arithmetic: the DATA_W x DATA_W product is truncated to its low DATA_W bits. Accumulation wraps modulo 2^DATA_W, so unsigned and two's-complement results are bit-identical. No saturation and no overflow flag.
- The multiply-accumulate uses the current inputs, not the registered operands. acc therefore reflects a sample one edge after it is presented.
- Operand latency, edge input to opposite edge output: 2 enabled edges. Example: N_RX0 sampled at edge k appears on N_RY0 after edge k+1.
- Outputs are pure register outputs, with no combinational paths from inputs.
- Feed protocol for C = A·B (2x2):
  - Row i of A is presented on N_RXi starting at cycle i.
  - Column j of B is presented on N_CXj starting at cycle j.
  - Zeros are fed elsewhere.
  - All ACC values are final after 4 enabled edges and remain stable while zeros are fed.
- No accumulator clear other than RST. A new multiplication requires RST between jobs.
- Reset asserted mid-computation discards all partial sums and in-flight operands.

Test Plan:
- Basic multiply: RST one cycle, then EN=1 with the sequences below over 5 edges.
  - N_RX0=1,2,0,0,0; N_RX1=0,3,4,0,0.
  - N_CX0=5,7,0,0,0; N_CX1=0,6,8,0,0.
  - Required: ACC00=19, ACC01=22, ACC10=43, ACC11=50.
  - Required: N_RY0 shows 1 after edge 2 and 2 after edge 3; N_CY1 shows 6 after edge 3 and 8 after edge 4.
- Enable hold: repeat the basic multiply with EN=0 for 2 cycles inserted after edge 2 (inputs held). Required: registers frozen during the stall; same final ACC values.
- Reset mid-run: assert RST after edge 2 of the basic multiply. Required: all ACC and edge outputs read 0 on the next cycle. A rerun from that point gives 19/22/43/50.
- Wrap-around: feed N_RX0=0xFFFFFFFF and N_CX0=2 for one edge, then zeros. Required: ACC00=0xFFFFFFFE and the other ACCs unchanged.
- Accumulation across jobs without reset: run the basic multiply twice back-to-back with no RST between. Required: ACC00=38, ACC01=44, ACC10=86, ACC11=100.
- Reset priority: RST=1 with EN=0 and nonzero inputs. Required: all registers are 0 after the edge.
